// File: rtl/hex_display_scanner_if.sv
// Bundles the syscall-side inputs and display-side outputs of hex_display_scanner.
interface hex_display_scanner_if;
  logic        load;
  logic [31:0] value;
  logic        halt;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output load, value, halt, input an, seg, dp);
  modport slave  (input load, value, halt, output an, seg, dp);
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit active-low seven-segment scanner with halt freeze and blink.
// Optional macro HEX_SCAN_LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_display_scanner_if.slave  bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

  logic [31:0]   disp_val;
  logic          halted;
  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  logic          tick_c;
  logic [3:0]    nibble_c;
  logic [6:0]    enc_c;
  logic          lz_blank_c;
  logic          blank_c;
  logic [7:0]    an_nxt_c;
  logic [6:0]    seg_nxt_c;
  logic          dp_nxt_c;

  assign tick_c = (prescaler == PW'(REFRESH_DIV - 1));

  // Capture, halt latch, prescaler, digit scan and blink timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val  <= 32'h0;
      halted    <= 1'b0;
      prescaler <= '0;
      digit_idx <= 3'd0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      if (bus.load && !halted) disp_val <= bus.value;
      if (bus.halt)            halted   <= 1'b1;
      prescaler <= tick_c ? '0 : prescaler + PW'(1);
      if (tick_c) begin
        digit_idx <= digit_idx + 3'd1;
        if (halted) begin
          if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end
    end
  end

  assign nibble_c = disp_val[{digit_idx, 2'b00} +: 4];

  always_comb begin
    enc_c = 7'h7F;
    unique case (nibble_c)
      4'h0: enc_c = 7'h40;  4'h1: enc_c = 7'h79;
      4'h2: enc_c = 7'h24;  4'h3: enc_c = 7'h30;
      4'h4: enc_c = 7'h19;  4'h5: enc_c = 7'h12;
      4'h6: enc_c = 7'h02;  4'h7: enc_c = 7'h78;
      4'h8: enc_c = 7'h00;  4'h9: enc_c = 7'h10;
      4'hA: enc_c = 7'h08;  4'hB: enc_c = 7'h03;
      4'hC: enc_c = 7'h46;  4'hD: enc_c = 7'h21;
      4'hE: enc_c = 7'h06;  4'hF: enc_c = 7'h0E;
      default: enc_c = 7'h7F;
    endcase
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [2:0] msd_c;

  // Index of the most significant nonzero nibble; digit 0 is never blanked
  always_comb begin
    msd_c = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (disp_val[4*k +: 4] != 4'h0) msd_c = 3'(k);
    end
  end

  assign lz_blank_c = (digit_idx > msd_c);
`else
  assign lz_blank_c = 1'b0;
`endif

  always_comb begin
    blank_c   = (halted && blink_off) || lz_blank_c;
    an_nxt_c  = blank_c ? 8'hFF : ~(8'h01 << digit_idx);
    seg_nxt_c = blank_c ? 7'h7F : enc_c;
    dp_nxt_c  = ~(halted && (digit_idx == 3'd0) && !blink_off);
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= 8'hFF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_nxt_c;
      bus.seg <= seg_nxt_c;
      bus.dp  <= dp_nxt_c;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized self-checking bench for hex_display_scanner against a cycle-count based reference model.
module tb_hex_display_scanner;

  localparam int unsigned RD = 4;
  localparam int unsigned BT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hex_display_scanner_if bus ();

  hex_display_scanner #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: edges since reset and ticks seen while halted
  logic [31:0] m_val;
  bit          m_halt;
  int          m_cnt;
  int          m_hticks;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic void model_reset();
    m_val = 32'h0; m_halt = 1'b0; m_cnt = 0; m_hticks = 0;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
  endfunction

  function automatic void model_outputs();
    int d;
    int msd;
    bit boff;
    bit blank;
    logic [31:0] nib;
    d     = (m_cnt / RD) % 8;
    boff  = ((m_hticks / BT) % 2) == 1;
    blank = m_halt && boff;
    msd   = 0;
    for (int k = 0; k < 8; k++)
      if (((m_val >> (4*k)) & 32'hF) != 0) msd = k;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    if (d > msd) blank = 1'b1;
`endif
    nib   = (m_val >> (4*d)) & 32'hF;
    e_an  = 8'hFF;
    if (!blank) e_an[d] = 1'b0;
    e_seg = blank ? 7'h7F : seg_tab[nib[3:0]];
    e_dp  = !(m_halt && d == 0 && !boff);
  endfunction

  function automatic void model_step();
    if ((m_cnt % RD) == RD - 1 && m_halt) m_hticks++;
    if (bus.load && !m_halt) m_val = bus.value;
    if (bus.halt) m_halt = 1'b1;
    m_cnt++;
  endfunction

  // One clock: model follows the edge, returns at the falling edge for sampling/driving
  task automatic cycle();
    @(posedge clk);
    model_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.load = 1'b0; bus.halt = 1'b0; bus.value = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b expected an=FF seg=7F dp=1", bus.an, bus.seg, bus.dp);
    end
    for (int i = 1; i <= 40; i++) begin
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL idle_scan cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
      if (i == 1 || i == 29 || i == 33) begin
        vectors++;
        if (bus.an !== ((i == 29) ? 8'h7F : 8'hFE) || bus.seg !== 7'h40) begin
          errors++;
          $display("FAIL idle_digit cyc%0d: an=%h seg=%h expected an=%h seg=40",
                   i, bus.an, bus.seg, (i == 29) ? 8'h7F : 8'hFE);
        end
      end
    end
  endtask

  task automatic test_load();
    int hits;
    hits = 0;
    apply_reset();
    bus.load = 1'b1; bus.value = 32'h0123ABCD;
    cycle();
    bus.load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL load_scan cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
      if (bus.an == 8'hFE || bus.an == 8'hEF) begin
        hits++;
        vectors++;
        if (bus.seg !== ((bus.an == 8'hFE) ? 7'h21 : 7'h30)) begin
          errors++;
          $display("FAIL load_digit an=%h: seg=%h expected %h", bus.an, bus.seg,
                   (bus.an == 8'hFE) ? 7'h21 : 7'h30);
        end
      end
    end
    vectors++;
    if (hits == 0) begin
      errors++;
      $display("FAIL load_digit_seen: hits=%0d expected >0", hits);
    end
  endtask

  task automatic test_random_loads();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bus.load  = ($urandom_range(3) == 0);
      bus.value = $urandom;
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL random_load cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_halt_blink();
    int hits;
    int blanks;
    hits = 0; blanks = 0;
    apply_reset();
    bus.load = 1'b1; bus.value = 32'h0000000A;
    cycle();
    bus.load = 1'b0; bus.halt = 1'b1;
    cycle();
    bus.halt = 1'b0; bus.load = 1'b1; bus.value = 32'hFFFFFFFF;
    cycle();
    for (int i = 0; i < 96; i++) begin
      bus.load  = ($urandom_range(1) == 0);
      bus.value = $urandom;
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL halt_blink cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
      if (bus.an == 8'hFF) blanks++;
      if (bus.an == 8'hFE) begin
        hits++;
        vectors++;
        if (bus.seg !== 7'h08 || bus.dp !== 1'b0) begin
          errors++;
          $display("FAIL halt_frozen: seg=%h dp=%b expected seg=08 dp=0", bus.seg, bus.dp);
        end
      end
    end
    bus.load = 1'b0;
    vectors++;
    if (hits == 0 || blanks < 32) begin
      errors++;
      $display("FAIL halt_blink_seen: digit0=%0d blank=%0d expected >0 and >=32", hits, blanks);
    end
  endtask

  task automatic test_back_to_back();
    int hits;
    hits = 0;
    apply_reset();
    bus.load = 1'b1; bus.halt = 1'b1; bus.value = 32'h00000005;
    cycle();
    bus.halt = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.load  = 1'b1;
      bus.value = $urandom;
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL load_halt_same cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
      if (bus.an == 8'hFE) begin
        hits++;
        vectors++;
        if (bus.seg !== 7'h12) begin
          errors++;
          $display("FAIL load_halt_frozen: seg=%h expected 12", bus.seg);
        end
      end
    end
    bus.load = 1'b0;
    vectors++;
    if (hits == 0) begin
      errors++;
      $display("FAIL load_halt_seen: hits=%0d expected >0", hits);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.load = 1'b1; bus.value = $urandom;
    cycle();
    bus.load = 1'b0; bus.halt = 1'b1;
    cycle();
    bus.halt = 1'b0;
    repeat (9 + $urandom_range(6)) cycle();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: an=%h seg=%h dp=%b expected an=FF seg=7F dp=1", bus.an, bus.seg, bus.dp);
    end
    apply_reset();
    for (int i = 0; i < 48; i++) begin
      cycle();
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
        errors++;
        $display("FAIL post_reset cyc%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 i, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
      end
    end
  endtask

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [31:0] vals [3];
    vals = '{32'h00000120, 32'h00000000, $urandom & 32'h000FFFFF};
    apply_reset();
    for (int v = 0; v < 3; v++) begin
      bus.load = 1'b1; bus.value = vals[v];
      cycle();
      bus.load = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cycle();
        vectors++;
        if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
          errors++;
          $display("FAIL lz_blank v=%h cyc%0d: an=%h seg=%h expected an=%h seg=%h",
                   vals[v], i, bus.an, bus.seg, e_an, e_seg);
        end
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0; bus.halt = 1'b0; bus.value = 32'h0;
    test_reset();
    test_load();
    test_random_loads();
    test_halt_blink();
    test_back_to_back();
    test_async_reset();
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed 8-digit seven-segment driver for the CPU board.
- Sits directly downstream of the syscall decoder. Consumes the 32-bit hex value written by the print-hex syscall (v0==1) and the halt flag (v0==10).
- Holds a shadow copy of the value and scans one digit per refresh tick. Active-low anodes and segments.
- After a halt, freezes the value and blinks the display.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range >= 2.
- BLINK_TICKS, 256: digit ticks per blink half-period after halt; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture strobe; value is sampled on any rising edge where load==1.
- value  input  32  hex value from the syscall decoder.
- halt  input  1  halt request from the syscall decoder; level or pulse.
- an  output  8  digit enables, active low; an[k] selects digit k, where k=0 is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.

Behaviour:
- Reset: asynchronous assert on rst_n=0, synchronous-style release on the next edge. Reset values:
  - disp_val=0, halted=0, prescaler=0, digit_idx=0, blink_cnt=0, blink_off=0
  - an=8'hFF, seg=7'h7F, dp=1
- Capture:
  - If load==1 and halted==0: disp_val<=value.
  - If halted==1: load is ignored and the value stays frozen.
  - load and halt asserted in the same cycle: the value is captured and halted is set; the frozen value is the new one.
- Halt latch: halt==1 sets halted. halted is sticky and is cleared only by rst_n.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 in the cycle where prescaler==REFRESH_DIV-1.
- Digit scan: on tick, digit_idx<=digit_idx+1, wrapping 7->0 (3-bit natural wrap).
- Blink (only while halted=1):
  - blink_cnt increments on each tick.
  - When blink_cnt reaches BLINK_TICKS-1 on a tick, blink_cnt<=0 and blink_off toggles.
  - Before halt, blink_cnt and blink_off stay at 0.
- Output register (1-cycle latency from digit_idx/disp_val/halted/blink_off):
  - an: all 1s if halted&&blink_off. Otherwise all 1s except bit digit_idx, which is 0.
  - seg: encoding of nibble disp_val[4*digit_idx+3 -: 4]. Blanked to 7'h7F when an is all 1s.
  - Encoding, active-low gfedcba, nibbles 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
  - dp: 0 only when halted==1, digit_idx==0 and the display is not in the blink-off phase. Otherwise 1.
- A new capture is visible from the next output-register update; there is no wait for the scan to wrap.
- Reset mid-scan: all state returns to reset values immediately; scanning restarts at digit 0, prescaler 0.

Optional Feature:
- Macro: HEX_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits k > the index of the most significant nonzero nibble of disp_val show an[k]=1 and seg=7'h7F in their slot.
  - Digit 0 is never blanked, so disp_val==0 shows "0" on digit 0 only.
  - The scan timing is unchanged: blanked digits still consume their slot.
- Undefined: all 8 digits are always driven, including leading zeros.

Test Plan (REFRESH_DIV=4, BLINK_TICKS=2 unless noted):
- Reset then release, no load -> an=FE, seg=40 on digit 0. Digit advances every 4 cycles. Digit 7 is an=7F. Sequence wraps back to an=FE after 32 cycles.
- load=1 with value=32'h0123ABCD for one cycle -> the scan shows nibbles D,C,B,A,3,2,1,0 on digits 0..7, with seg=21,46,03,08,30,24,79,40.
- halt pulse after value=32'h0000000A is loaded, then load=1 with value=32'hFFFFFFFF -> the display stays A on digit 0 with dp=0. an is forced to FF for 2 digit ticks, then active for 2 ticks, alternating.
- load and halt in the same cycle with value=32'h00000005 -> 5 is frozen (seg=12 on digit 0) and blinking starts; later loads are ignored.
- rst_n=0 asserted asynchronously while halted mid-slot -> an=FF, seg=7F and dp=1 without waiting for a clock edge. After release, normal scanning of value 0 resumes and halt is cleared.
- With HEX_SCAN_LEADING_ZERO_BLANK_EN, value=32'h00000120 -> digits 0..2 show 0,2,1 and digits 3..7 stay an=FF; value=0 -> only digit 0 shows "0".
